// File: rtl/alu_uart_interface.sv
// Frame sequencer between the UART and the ALU: collects A, B and opcode bytes,
// latches the ALU result and hands it to the transmitter with a start/done handshake.
module alu_uart_interface #(
  parameter int NB_DATA        = 8,
  parameter int NB_OPCODE      = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NB_DATA-1:0]   rx_data,
  input  logic                 rx_done,
  input  logic                 tx_done,
  input  logic [NB_DATA-1:0]   alu_out,
  output logic [NB_DATA-1:0]   dato_a,
  output logic [NB_DATA-1:0]   dato_b,
  output logic [NB_OPCODE-1:0] opcode,
  output logic [NB_DATA-1:0]   tx_data,
  output logic                 tx_start,
  output logic                 busy,
  output logic                 opcode_err,
  output logic                 timeout,
  output logic                 overrun
);

  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [NB_OPCODE-1:0] OP_ADD = NB_OPCODE'(6'b100000);
  localparam logic [NB_OPCODE-1:0] OP_SUB = NB_OPCODE'(6'b100010);
  localparam logic [NB_OPCODE-1:0] OP_AND = NB_OPCODE'(6'b100100);
  localparam logic [NB_OPCODE-1:0] OP_OR  = NB_OPCODE'(6'b100101);
  localparam logic [NB_OPCODE-1:0] OP_XOR = NB_OPCODE'(6'b100110);
  localparam logic [NB_OPCODE-1:0] OP_NOR = NB_OPCODE'(6'b100111);
  localparam logic [NB_OPCODE-1:0] OP_SRA = NB_OPCODE'(6'b000011);
  localparam logic [NB_OPCODE-1:0] OP_SRL = NB_OPCODE'(6'b000010);

  typedef enum logic [2:0] {
    ST_IDLE, ST_WAIT_B, ST_WAIT_OP, ST_EXEC, ST_SEND, ST_WAIT_TX
  } state_t;

  state_t        state;
  logic [CW-1:0] to_cnt;
  logic          op_valid;
  logic          to_hit;

  // Opcode byte is legal only with the unused high bits clear.
  always_comb begin
    op_valid = 1'b0;
    if (rx_data[NB_DATA-1:NB_OPCODE] == '0) begin
      case (rx_data[NB_OPCODE-1:0])
        OP_ADD, OP_SUB, OP_AND, OP_OR,
        OP_XOR, OP_NOR, OP_SRA, OP_SRL: op_valid = 1'b1;
        default:                        op_valid = 1'b0;
      endcase
    end
  end

  assign to_hit = TO_EN && (to_cnt == CNT_LIMIT);
  assign busy   = (state == ST_EXEC) || (state == ST_SEND) || (state == ST_WAIT_TX);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      to_cnt     <= '0;
      dato_a     <= '0;
      dato_b     <= '0;
      opcode     <= '0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      opcode_err <= 1'b0;
      timeout    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      tx_start   <= 1'b0;
      opcode_err <= 1'b0;
      timeout    <= 1'b0;
      // Bytes arriving while a result is in flight are dropped but remembered.
      if (rx_done && busy) overrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (rx_done) begin
            dato_a <= rx_data;
            to_cnt <= '0;
            state  <= ST_WAIT_B;
          end
        end
        ST_WAIT_B: begin
          if (rx_done) begin
            dato_b <= rx_data;
            to_cnt <= '0;
            state  <= ST_WAIT_OP;
          end else if (to_hit) begin
            timeout <= 1'b1;
            to_cnt  <= '0;
            state   <= ST_IDLE;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        ST_WAIT_OP: begin
          if (rx_done) begin
            to_cnt <= '0;
            if (op_valid) begin
              opcode <= rx_data[NB_OPCODE-1:0];
              state  <= ST_EXEC;
            end else begin
              opcode_err <= 1'b1;
              state      <= ST_IDLE;
            end
          end else if (to_hit) begin
            timeout <= 1'b1;
            to_cnt  <= '0;
            state   <= ST_IDLE;
          end else if (TO_EN) begin
            to_cnt <= to_cnt + CW'(1);
          end
        end
        ST_EXEC: begin
          tx_data <= alu_out;
          state   <= ST_SEND;
        end
        ST_SEND: begin
          tx_start <= 1'b1;
          state    <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (tx_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_uart_interface.sv
// Bench for alu_uart_interface: directed frames with literal expectations plus
// randomized byte traffic checked each cycle against a transaction-level model.
module tb_alu_uart_interface;

  localparam int T = 16;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       tx_done;
  logic [7:0] alu_out;
  logic [7:0] dato_a, dato_b, tx_data;
  logic [5:0] opcode;
  logic       tx_start, busy, opcode_err, timeout, overrun;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_uart_interface #(.NB_DATA(8), .NB_OPCODE(6), .TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n), .rx_data(rx_data), .rx_done(rx_done),
    .tx_done(tx_done), .alu_out(alu_out), .dato_a(dato_a), .dato_b(dato_b),
    .opcode(opcode), .tx_data(tx_data), .tx_start(tx_start), .busy(busy),
    .opcode_err(opcode_err), .timeout(timeout), .overrun(overrun)
  );

  always #5 clock = ~clock;

  logic [5:0] valid_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    logic signed [7:0] sa;
    sa = a;
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      6'h27:   return ~(a | b);
      6'h03:   return sa >>> b;
      6'h02:   return a >> b;
      default: return 8'h00;
    endcase
  endfunction

  // ALU stand-in driven from the DUT's registered operands.
  always_comb alu_out = alu_f(dato_a, dato_b, opcode);

  function automatic bit is_valid(input logic [7:0] b);
    if (b[7:6] != 2'b00) return 1'b0;
    foreach (valid_ops[i]) if (valid_ops[i] == b[5:0]) return 1'b1;
    return 1'b0;
  endfunction

  // Model: bytes collected so far, idle edges since the last byte, and the age
  // (in edges) of the result in flight (-1 = nothing in flight).
  typedef struct {
    logic [7:0] a, b, txd;
    logic [5:0] op;
    int         nbytes, idle, age;
    bit         start, err, to, ovr;
  } model_t;

  function automatic model_t model_reset();
    model_t m;
    m.a = 0; m.b = 0; m.txd = 0; m.op = 0;
    m.nbytes = 0; m.idle = 0; m.age = -1;
    m.start = 0; m.err = 0; m.to = 0; m.ovr = 0;
    return m;
  endfunction

  function automatic model_t model_step(input model_t m, input bit rxd,
                                        input logic [7:0] rxb, input bit txd);
    model_t n = m;
    n.start = 0; n.err = 0; n.to = 0;
    if (m.age >= 0) begin
      if (rxd) n.ovr = 1;
      if (m.age == 0) begin n.txd = alu_f(m.a, m.b, m.op); n.age = 1; end
      else if (m.age == 1) begin n.start = 1; n.age = 2; end
      else if (txd) n.age = -1;
    end else if (rxd) begin
      n.idle = 0;
      if (m.nbytes == 0) begin n.a = rxb; n.nbytes = 1; end
      else if (m.nbytes == 1) begin n.b = rxb; n.nbytes = 2; end
      else begin
        n.nbytes = 0;
        if (is_valid(rxb)) begin n.op = rxb[5:0]; n.age = 0; end
        else n.err = 1;
      end
    end else if (m.nbytes > 0) begin
      n.idle = m.idle + 1;
      if (n.idle == T) begin n.to = 1; n.nbytes = 0; n.idle = 0; end
    end
    return n;
  endfunction

  model_t m;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) m <= model_reset();
    else          m <= model_step(m, rx_done, rx_data, tx_done);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("m_dato_a",     32'(dato_a),     32'(m.a));
      check("m_dato_b",     32'(dato_b),     32'(m.b));
      check("m_opcode",     32'(opcode),     32'(m.op));
      check("m_tx_data",    32'(tx_data),    32'(m.txd));
      check("m_tx_start",   32'(tx_start),   32'(m.start));
      check("m_busy",       32'(busy),       32'(m.age >= 0));
      check("m_opcode_err", 32'(opcode_err), 32'(m.err));
      check("m_timeout",    32'(timeout),    32'(m.to));
      check("m_overrun",    32'(overrun),    32'(m.ovr));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_dato_a"},  32'(dato_a),  0);
    check({tag, "_dato_b"},  32'(dato_b),  0);
    check({tag, "_opcode"},  32'(opcode),  0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_flags"},
          32'({tx_start, busy, opcode_err, timeout, overrun}), 0);
  endtask

  // Full frame with literal latency checks; optional byte injected during WAIT_TX.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                           input logic [7:0] exp, input bit inject);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    check("f_dato_a", 32'(dato_a), 32'(a));
    check("f_dato_b", 32'(dato_b), 32'(b));
    check("f_opcode", 32'(opcode), 32'(op[5:0]));
    check("f_busy_n0", 32'(busy), 1);
    check("f_start_n0", 32'(tx_start), 0);
    tick();
    check("f_tx_data_n1", 32'(tx_data), 32'(exp));
    check("f_start_n1", 32'(tx_start), 0);
    tick();
    check("f_start_n2", 32'(tx_start), 1);
    tick();
    check("f_start_n3", 32'(tx_start), 0);
    if (inject) begin
      send_byte(8'h55);
      check("ovr_set", 32'(overrun), 1);
      check("ovr_tx_data", 32'(tx_data), 32'(exp));
      check("ovr_dato_a", 32'(dato_a), 32'(a));
    end else begin
      tick();
    end
    tick();
    tick();
    check("f_busy_wait", 32'(busy), 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("f_busy_after_done", 32'(busy), 0);
    check("f_tx_data_held", 32'(tx_data), 32'(exp));
  endtask

  function automatic logic [7:0] pick_byte();
    int r = $urandom_range(9);
    if (r < 5) return {2'b00, valid_ops[$urandom_range(7)]};
    if (r == 5) return {2'($urandom_range(1, 3)), valid_ops[$urandom_range(7)]};
    return 8'($urandom);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    rx_done = 1'b0;
    tx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("rst");
    chk_en = 1'b1;
    reset_n = 1'b1;
    tick();

    run_frame(8'h05, 8'h03, 8'h20, 8'h08, 1'b0);
    run_frame(8'h03, 8'h05, 8'h22, 8'hFE, 1'b0);
    run_frame(8'h80, 8'h02, 8'h03, 8'hE0, 1'b0);
    run_frame(8'h80, 8'h02, 8'h02, 8'h20, 1'b0);

    // Invalid opcode bytes: one-cycle error pulse, no transmission, opcode kept.
    foreach (valid_ops[i]) begin
      if (i == 0) begin
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h3F);
        check("err_pulse_3f", 32'(opcode_err), 1);
        check("err_opcode_3f", 32'(opcode), 32'h02);
        check("err_busy_3f", 32'(busy), 0);
        tick();
        check("err_clear_3f", 32'({opcode_err, tx_start}), 0);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'hA0);
        check("err_pulse_a0", 32'(opcode_err), 1);
        check("err_opcode_a0", 32'(opcode), 32'h02);
        tick();
        check("err_clear_a0", 32'({opcode_err, tx_start, busy}), 0);
      end
    end

    // Timeout fires on the 16th idle edge after the first byte.
    send_byte(8'h01);
    repeat (T - 1) tick();
    check("to_not_yet", 32'(timeout), 0);
    tick();
    check("to_pulse", 32'(timeout), 1);
    check("to_dato_a_kept", 32'(dato_a), 32'h01);
    tick();
    check("to_clear", 32'(timeout), 0);
    // Byte landing exactly on the limit edge wins over the timeout.
    send_byte(8'h07);
    check("to2_dato_a", 32'(dato_a), 32'h07);
    repeat (T - 1) tick();
    send_byte(8'h09);
    check("to2_no_timeout", 32'(timeout), 0);
    check("to2_dato_b", 32'(dato_b), 32'h09);
    send_byte(8'h20);
    check("to2_busy", 32'(busy), 1);
    repeat (3) tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("to2_tx_data", 32'(tx_data), 32'h10);

    run_frame(8'h0F, 8'h3C, 8'h24, 8'h0C, 1'b1);
    run_frame(8'h02, 8'h02, 8'h20, 8'h04, 1'b0);
    check("ovr_sticky", 32'(overrun), 1);

    // Asynchronous reset right after the start pulse.
    send_byte(8'h05); send_byte(8'h05); send_byte(8'h20);
    tick(); tick();
    check("rst_pre_start", 32'(tx_start), 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("arst");
    #3 reset_n = 1'b1;
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("late_done_ignored", 32'({busy, tx_start}), 0);
    run_frame(8'h06, 8'h03, 8'h27, 8'hF8, 1'b0);
    check("rst_ovr_cleared", 32'(overrun), 0);

    // Random traffic: alternate dense segments and sparse ones that provoke timeouts.
    for (int seg = 0; seg < 40; seg++) begin
      int p;
      p = (seg % 4 == 3) ? 25 : 3;
      for (int c = 0; c < 80; c++) begin
        rx_done = ($urandom_range(p - 1) == 0);
        rx_data = pick_byte();
        tx_done = ($urandom_range(5) == 0);
        tick();
      end
    end
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
Name: alu_uart_interface

Overview:
- Frame sequencer between the UART receiver/transmitter and the ALU.
- Collects a 3-byte frame from the UART receiver (operand A, operand B, opcode) and drives the ALU operand/opcode inputs from registers.
- Samples the combinational ALU result and hands it to the UART transmitter with a start/done handshake.
- Validates opcodes, enforces an inter-byte timeout and flags bytes that arrive while a result is in flight.

Parameters:
NB_DATA, 8, UART byte width and ALU operand/result width
NB_OPCODE, 6, ALU opcode width
TIMEOUT_CYCLES, 50000, max clock cycles allowed between frame bytes; 0 disables the timeout

Ports:
clock  input  1  system clock, all registers on rising edge
reset_n  input  1  asynchronous, active-low reset
rx_data  input  NB_DATA  byte from UART receiver, valid when rx_done=1
rx_done  input  1  single-cycle pulse, one byte received
tx_done  input  1  single-cycle pulse, transmitter finished the byte
alu_out  input  NB_DATA  combinational ALU result
dato_a  output  NB_DATA  registered operand A to ALU
dato_b  output  NB_DATA  registered operand B to ALU
opcode  output  NB_OPCODE  registered opcode to ALU
tx_data  output  NB_DATA  result byte to transmitter, held until tx_done
tx_start  output  1  single-cycle pulse requesting transmission
busy  output  1  high in EXEC, SEND, WAIT_TX
opcode_err  output  1  single-cycle pulse, invalid opcode byte received
timeout  output  1  single-cycle pulse, frame aborted by inter-byte timeout
overrun  output  1  sticky, byte received while busy; cleared only by reset

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE.
  - dato_a, dato_b, opcode, tx_data = 0.
  - tx_start, opcode_err, timeout, overrun = 0; timeout counter = 0.
  - Applies immediately mid-frame or mid-transmit; tx_start drops in the same cycle.
- Valid opcodes: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100110 XOR, 100111 NOR, 000011 SRA, 000010 SRL. The opcode byte is valid only if bits [7:6]=00 and bits [5:0] match one of these.
- FSM transitions:
  - IDLE: on rx_done, dato_a<=rx_data, go to WAIT_B, clear counter.
  - WAIT_B: on rx_done, dato_b<=rx_data, go to WAIT_OP, clear counter.
  - WAIT_OP, rx_done with valid byte: opcode<=rx_data[5:0], go to EXEC.
  - WAIT_OP, rx_done with invalid byte: opcode_err=1 for one cycle, go to IDLE. Opcode register keeps its previous value. No transmission.
  - EXEC (exactly 1 cycle): tx_data<=alu_out, go to SEND.
  - SEND (exactly 1 cycle): tx_start=1, go to WAIT_TX.
  - WAIT_TX: on tx_done, go to IDLE. tx_data is held stable throughout.
- Latency: if the opcode rx_done is sampled at edge N, tx_data is valid after edge N+1 and tx_start is high from edge N+2 to edge N+3.
- Timeout:
  - Counter increments each cycle in WAIT_B and WAIT_OP while rx_done=0.
  - When it reaches TIMEOUT_CYCLES-1, timeout=1 for one cycle, go to IDLE, counter clears. Operand registers are not cleared.
  - rx_done arriving in the cycle the limit is reached takes priority: the byte is accepted and no timeout fires.
  - IDLE has no timeout.
  - Counter width is $clog2(TIMEOUT_CYCLES+1); no wrap-around is possible because it clears at the limit.
- Overrun: rx_done in EXEC, SEND or WAIT_TX sets overrun=1 and the byte is dropped; the FSM and registers are unaffected.
- tx_done outside WAIT_TX is ignored.
- dato_a/dato_b/opcode hold their values between frames. A new frame overwrites dato_a on its first byte.
- Arithmetic is performed entirely by the ALU; this block does no arithmetic besides the counter.

Test Plan:
- Reset, then bytes 0x05, 0x03, 0x20 (ADD), then tx_done 5 cycles after tx_start -> dato_a=0x05, dato_b=0x03, opcode=100000; tx_data=0x08; one tx_start pulse exactly 2 cycles after the opcode rx_done; busy falls the cycle after tx_done.
- Bytes 0x03, 0x05, 0x22 (SUB) -> tx_data=0xFE. Bytes 0x80, 0x02, 0x03 (SRA) -> tx_data=0xE0. Bytes 0x80, 0x02, 0x02 (SRL) -> tx_data=0x20.
- Bytes 0x11, 0x22, 0x3F -> opcode_err pulse of 1 cycle, no tx_start, state IDLE, opcode unchanged. Byte 0xA0 as opcode (bits [7:6]≠0) -> same response.
- TIMEOUT_CYCLES=16, send 0x01 then wait 20 cycles -> timeout pulse exactly 16 cycles after the first byte, return to IDLE. A second run with rx_done landing on cycle 15 -> byte accepted, no timeout.
- During WAIT_TX inject rx_done with 0x55 -> overrun=1 and stays 1; tx_data unchanged. The next frame 0x02, 0x02, 0x20 still yields 0x04.
- Assert reset_n=0 in WAIT_TX with tx_start just pulsed -> all outputs 0 immediately. After release, a fresh 3-byte frame processes normally and the late tx_done is ignored.
